// File: rtl/shell_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART command shell.
// The reply-kind enum tells LOAD which text to build for the TX serializer.
package shell_pkg;

    typedef enum logic [2:0] {
        ST_LINE  = 3'd0,
        ST_PARSE = 3'd1,
        ST_BUS   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SEND  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        RSP_READ = 3'd0,
        RSP_OK   = 3'd1,
        RSP_RUN  = 3'd2,
        RSP_HALT = 3'd3,
        RSP_ERR  = 3'd4,
        RSP_TMO  = 3'd5
    } rsp_e;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_SP = 8'h20;

    localparam logic [7:0] CMD_READ   = 8'h72; // 'r'
    localparam logic [7:0] CMD_WRITE  = 8'h77; // 'w'
    localparam logic [7:0] CMD_ROM_RD = 8'h64; // 'd'
    localparam logic [7:0] CMD_ROM_WR = 8'h72; // 'r'
    localparam logic [7:0] CMD_RAM    = 8'h6D; // 'm'
    localparam logic [7:0] CMD_GO     = 8'h67; // 'g'
    localparam logic [7:0] CMD_HALT   = 8'h68; // 'h'

    // Returns {valid, nibble}; valid is 0 for anything outside 0-9, a-f, A-F.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [7:0] t;
        logic       v;
        t = 8'h00;
        v = 1'b1;
        if (c >= 8'h30 && c <= 8'h39) begin
            t = c - 8'h30;
        end else if (c >= 8'h61 && c <= 8'h66) begin
            t = c - 8'h57;
        end else if (c >= 8'h41 && c <= 8'h46) begin
            t = c - 8'h37;
        end else begin
            v = 1'b0;
        end
        return {v, t[3:0]};
    endfunction

    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = hex_decode(c);
        return r[3:0];
    endfunction

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/shell_tx_serializer.sv
// Reply buffer plus ready/valid byte streamer; byte 0 of data_i goes out first.
// done_o is high in the cycle of the final handshake.
module shell_tx_serializer #(
    parameter int NBYTES = 7,
    parameter int LEN_W  = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                load_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic [NBYTES*8-1:0] data_i,
    output logic                tx_valid_o,
    output logic [7:0]          tx_byte_o,
    input  logic                tx_ready_i,
    output logic                done_o
);

    logic [NBYTES*8-1:0] reply_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx_q;
    logic                valid_q;
    logic                last;

    assign last       = (idx_q + LEN_W'(1)) == len_q;
    assign done_o     = valid_q & tx_ready_i & last;
    assign tx_valid_o = valid_q;
    // Byte comes straight from registers, so it cannot move while stalled.
    assign tx_byte_o  = reply_q[int'(idx_q)*8 +: 8];

    always_ff @(posedge CLK) begin
        if (RST) begin
            reply_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            reply_q <= data_i;
            len_q   <= len_i;
            idx_q   <= '0;
            valid_q <= (len_i != '0);
        end else if (valid_q && tx_ready_i) begin
            if (last) begin
                valid_q <= 1'b0;
            end else begin
                idx_q <= idx_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/shell_cmd_engine.sv
// UART command interpreter: assembles CR-terminated lines, runs rd/rm/wr/wm
// bus accesses or g/h run control, and streams an ASCII reply.
module shell_cmd_engine
    import shell_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int LINE_MAX    = 16,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_byte,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_ready,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic              o_bus_space,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [DATA_W-1:0] i_bus_rdata,
    output logic              o_running,
    output logic              o_busy,
    output logic [2:0]        o_dbg_state
);

    localparam int A         = ADDR_W / 4;
    localparam int D         = DATA_W / 4;
    localparam int IDX_W     = $clog2(LINE_MAX + 1);
    localparam int BUF_AW    = $clog2(LINE_MAX);
    localparam int TMO_W     = $clog2(BUS_TIMEOUT + 1);
    localparam int REPLY_MAX = (D + 3 > 7) ? D + 3 : 7;
    localparam int RLEN_W    = $clog2(REPLY_MAX + 1);

    localparam logic [IDX_W-1:0] LEN_RD   = IDX_W'(3 + A);
    localparam logic [IDX_W-1:0] LEN_WR   = IDX_W'(4 + A + D);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(LINE_MAX);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT - 1);

    state_e              state_q;
    rsp_e                rsp_q;
    logic [7:0]          line_q [LINE_MAX];
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    len_q;
    logic                ovf_q;
    logic                running_q;
    logic                req_q;
    logic                we_q;
    logic                space_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [TMO_W-1:0]    tmo_q;

    logic                  addr_hex, data_hex;
    logic [4:0]            hx;
    logic [ADDR_W-1:0]     p_addr;
    logic [DATA_W-1:0]     p_data;
    logic                  is_rd, is_wr, is_go, is_halt, p_space;
    logic [REPLY_MAX*8-1:0] reply_d;
    logic [RLEN_W-1:0]     reply_len_d;
    logic                  tx_done;

    // Field decode; fixed positions, so only len and separators select the command.
    always_comb begin
        addr_hex = 1'b1;
        data_hex = 1'b1;
        p_addr   = '0;
        p_data   = '0;
        hx       = '0;
        for (int i = 0; i < A; i++) begin
            hx = hex_decode(line_q[3 + i]);
            addr_hex = addr_hex & hx[4];
            p_addr[ADDR_W - 1 - 4*i -: 4] = hx[3:0];
        end
        for (int i = 0; i < D; i++) begin
            hx = hex_decode(line_q[4 + A + i]);
            data_hex = data_hex & hx[4];
            p_data[DATA_W - 1 - 4*i -: 4] = hx[3:0];
        end
    end

    assign p_space = (line_q[1] == CMD_RAM);
    assign is_rd   = (line_q[0] == CMD_READ) && (line_q[1] == CMD_ROM_RD || p_space)
                     && (len_q == LEN_RD) && (line_q[2] == CH_SP) && addr_hex;
    assign is_wr   = (line_q[0] == CMD_WRITE) && (line_q[1] == CMD_ROM_WR || p_space)
                     && (len_q == LEN_WR) && (line_q[2] == CH_SP)
                     && (line_q[3 + A] == CH_SP) && addr_hex && data_hex;
    assign is_go   = (len_q == IDX_W'(1)) && (line_q[0] == CMD_GO);
    assign is_halt = (len_q == IDX_W'(1)) && (line_q[0] == CMD_HALT);

    always_comb begin
        reply_d       = '0;
        reply_len_d   = '0;
        reply_d[7:0]  = CH_LF;
        case (rsp_q)
            RSP_READ: begin
                for (int i = 0; i < D; i++) begin
                    reply_d[(1 + i)*8 +: 8] = nibble_to_hex(rdata_q[DATA_W - 1 - 4*i -: 4]);
                end
                reply_d[(1 + D)*8 +: 8] = CH_CR;
                reply_d[(2 + D)*8 +: 8] = CH_LF;
                reply_len_d = RLEN_W'(D + 3);
            end
            RSP_OK: begin
                reply_d[39:8] = {CH_LF, CH_CR, 8'h6B, 8'h6F};
                reply_len_d   = RLEN_W'(5);
            end
            RSP_RUN: begin
                reply_d[47:8] = {CH_LF, CH_CR, 8'h6E, 8'h75, 8'h72};
                reply_len_d   = RLEN_W'(6);
            end
            RSP_HALT: begin
                reply_d[55:8] = {CH_LF, CH_CR, 8'h74, 8'h6C, 8'h61, 8'h68};
                reply_len_d   = RLEN_W'(7);
            end
            RSP_TMO: begin
                reply_d[31:8] = {CH_LF, CH_CR, 8'h21};
                reply_len_d   = RLEN_W'(4);
            end
            default: begin
                reply_d[31:8] = {CH_LF, CH_CR, 8'h3F};
                reply_len_d   = RLEN_W'(4);
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_LINE;
            rsp_q     <= RSP_ERR;
            idx_q     <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            space_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            tmo_q     <= '0;
        end else begin
            case (state_q)
                ST_LINE: begin
                    if (i_rx_valid) begin
                        if (i_rx_byte == CH_CR) begin
                            len_q   <= idx_q;
                            idx_q   <= '0;
                            state_q <= ST_PARSE;
                        end else if (i_rx_byte == CH_BS) begin
                            if (idx_q != '0) idx_q <= idx_q - IDX_W'(1);
                        end else if (idx_q == IDX_FULL) begin
                            ovf_q <= 1'b1;
                        end else begin
                            line_q[idx_q[BUF_AW-1:0]] <= i_rx_byte;
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_PARSE: begin
                    ovf_q   <= 1'b0;
                    rsp_q   <= RSP_ERR;
                    state_q <= ST_LOAD;
                    if (!ovf_q) begin
                        if ((is_rd || is_wr) && !running_q) begin
                            state_q <= ST_BUS;
                            req_q   <= 1'b1;
                            we_q    <= is_wr;
                            space_q <= p_space;
                            addr_q  <= p_addr;
                            wdata_q <= is_wr ? p_data : '0;
                            tmo_q   <= '0;
                        end else if (is_go) begin
                            running_q <= 1'b1;
                            rsp_q     <= RSP_RUN;
                        end else if (is_halt) begin
                            running_q <= 1'b0;
                            rsp_q     <= RSP_HALT;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack is checked first so an ack on the expiry cycle wins.
                    if (i_bus_ack) begin
                        req_q   <= 1'b0;
                        rsp_q   <= we_q ? RSP_OK : RSP_READ;
                        state_q <= ST_LOAD;
                        if (!we_q) rdata_q <= i_bus_rdata;
                    end else if (tmo_q == TMO_LAST) begin
                        req_q   <= 1'b0;
                        rsp_q   <= RSP_TMO;
                        state_q <= ST_LOAD;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_LOAD: state_q <= ST_SEND;
                ST_SEND: if (tx_done) state_q <= ST_LINE;
                default: state_q <= ST_LINE;
            endcase
        end
    end

    shell_tx_serializer #(
        .NBYTES (REPLY_MAX),
        .LEN_W  (RLEN_W)
    ) u_tx (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (state_q == ST_LOAD),
        .len_i      (reply_len_d),
        .data_i     (reply_d),
        .tx_valid_o (o_tx_valid),
        .tx_byte_o  (o_tx_byte),
        .tx_ready_i (i_tx_ready),
        .done_o     (tx_done)
    );

    assign o_bus_req   = req_q;
    assign o_bus_we    = we_q;
    assign o_bus_space = space_q;
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;
    assign o_running   = running_q;
    assign o_busy      = (state_q != ST_LINE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_shell_cmd_engine.sv
// Directed bench for shell_cmd_engine: line entry, bus read/write, errors,
// overflow, timeout, backspace, TX back-pressure and mid-reply reset.
module tb_shell_cmd_engine;

    logic        clk = 1'b0;
    logic        RST;
    logic        i_rx_valid;
    logic [7:0]  i_rx_byte;
    logic        o_tx_valid;
    logic [7:0]  o_tx_byte;
    logic        i_tx_ready;
    logic        o_bus_req;
    logic        o_bus_we;
    logic        o_bus_space;
    logic [15:0] o_bus_addr;
    logic [15:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [15:0] i_bus_rdata;
    logic        o_running;
    logic        o_busy;
    logic [2:0]  o_dbg_state;

    int total = 0;
    int bad   = 0;
    int lat;

    bit          ack_en       = 1'b1;
    int          ack_delay    = 0;
    logic [15:0] rdata_val    = 16'h0000;
    int          req_cnt      = 0;
    int          last_req_len = 0;
    bit          req_seen     = 1'b0;
    logic        seen_we      = 1'b0;
    logic        seen_space   = 1'b0;
    logic [15:0] seen_addr    = 16'h0000;
    logic [15:0] seen_wdata   = 16'h0000;

    // clock / reset
    always #5 clk = ~clk;

    shell_cmd_engine #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .LINE_MAX    (16),
        .BUS_TIMEOUT (255)
    ) dut (
        .CLK         (clk),
        .RST         (RST),
        .i_rx_valid  (i_rx_valid),
        .i_rx_byte   (i_rx_byte),
        .o_tx_valid  (o_tx_valid),
        .o_tx_byte   (o_tx_byte),
        .i_tx_ready  (i_tx_ready),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_space (o_bus_space),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata),
        .o_running   (o_running),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    // Bus responder: acks in req cycle ack_delay+1, records what it saw.
    initial begin
        i_bus_ack   = 1'b0;
        i_bus_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (o_bus_req) begin
                req_seen = 1'b1;
                req_cnt++;
                if (ack_en && req_cnt == ack_delay + 1) begin
                    i_bus_ack   = 1'b1;
                    i_bus_rdata = rdata_val;
                    seen_we     = o_bus_we;
                    seen_space  = o_bus_space;
                    seen_addr   = o_bus_addr;
                    seen_wdata  = o_bus_wdata;
                end else begin
                    i_bus_ack = 1'b0;
                end
            end else begin
                if (req_cnt > 0) last_req_len = req_cnt;
                req_cnt   = 0;
                i_bus_ack = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_byte  = b;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        send_byte(8'h0D);
    endtask

    // scoreboard: expected reply bytes are popped on each handshake
    task automatic collect_reply(input string exp_s, input string tag, input bit toggle,
                                 output int first_lat);
        logic [7:0] exp_q[$];
        logic [7:0] prev_byte;
        bit         prev_stall;
        int         n;
        exp_q = {};
        for (int i = 0; i < exp_s.len(); i++) exp_q.push_back(exp_s[i]);
        n          = exp_s.len();
        first_lat  = -1;
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        if (toggle) i_tx_ready = 1'b0;
        for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            i_tx_ready = toggle ? ~i_tx_ready : 1'b1;
            if (o_tx_valid && first_lat < 0) first_lat = cyc;
            if (o_tx_valid && prev_stall) chk({tag, " hold"}, {24'h0, o_tx_byte}, {24'h0, prev_byte});
            if (o_tx_valid && i_tx_ready)
                chk($sformatf("%s byte%0d", tag, n - exp_q.size()), {24'h0, o_tx_byte},
                    {24'h0, exp_q.pop_front()});
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_byte  = o_tx_byte;
        end
        chk({tag, " missing_bytes"}, exp_q.size(), 0);
        @(negedge clk);
        i_tx_ready = 1'b1;
        chk({tag, " valid_drop"}, {31'h0, o_tx_valid}, 0);
        chk({tag, " idle"}, {31'h0, o_busy}, 0);
    endtask

    initial begin
        RST        = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_byte  = 8'h00;
        i_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst tx_valid", {31'h0, o_tx_valid}, 0);
        chk("rst bus_req", {31'h0, o_bus_req}, 0);
        chk("rst running", {31'h0, o_running}, 0);
        chk("rst busy", {31'h0, o_busy}, 0);
        chk("rst state", {29'h0, o_dbg_state}, 0);
        chk("rst addr", {16'h0, o_bus_addr}, 0);
        RST = 1'b0;
        @(negedge clk);

        // ROM read, late ack, TX back-pressure
        ack_en = 1'b1; ack_delay = 5; rdata_val = 16'hBEEF;
        send_line("rd 1234");
        collect_reply("\nBEEF\r\n", "rd1234", 1'b1, lat);
        chk("rd1234 we", {31'h0, seen_we}, 0);
        chk("rd1234 space", {31'h0, seen_space}, 0);
        chk("rd1234 addr", {16'h0, seen_addr}, 32'h1234);

        // RAM write, immediate ack, latency
        ack_delay = 0;
        send_line("wm 00ff a5A5");
        collect_reply("\nok\r\n", "wm", 1'b0, lat);
        chk("wm latency", lat, 3);
        chk("wm we", {31'h0, seen_we}, 1);
        chk("wm space", {31'h0, seen_space}, 1);
        chk("wm addr", {16'h0, seen_addr}, 32'h00FF);
        chk("wm wdata", {16'h0, seen_wdata}, 32'hA5A5);

        // malformed lines, run/halt
        req_seen = 1'b0;
        send_line("rd 12G4");
        collect_reply("\n?\r\n", "badhex", 1'b0, lat);
        send_line("rd 123");
        collect_reply("\n?\r\n", "shortaddr", 1'b0, lat);
        chk("malformed no_req", {31'h0, req_seen}, 0);
        send_line("g");
        collect_reply("\nrun\r\n", "go", 1'b0, lat);
        chk("go latency", lat, 2);
        chk("go running", {31'h0, o_running}, 1);
        req_seen = 1'b0;
        send_line("rd 0000");
        collect_reply("\n?\r\n", "rd_while_run", 1'b0, lat);
        chk("rd_while_run no_req", {31'h0, req_seen}, 0);
        send_line("h");
        collect_reply("\nhalt\r\n", "halt", 1'b0, lat);
        chk("halt running", {31'h0, o_running}, 0);

        // overflow then recovery
        req_seen = 1'b0;
        send_line("abcdefghijklmnopqrst");
        collect_reply("\n?\r\n", "overflow", 1'b1, lat);
        chk("overflow no_req", {31'h0, req_seen}, 0);
        rdata_val = 16'h1A2F;
        send_line("rd 0001");
        collect_reply("\n1A2F\r\n", "after_ovf", 1'b0, lat);
        chk("after_ovf addr", {16'h0, seen_addr}, 32'h0001);

        // bus timeout
        ack_en = 1'b0;
        send_line("rd 0010");
        collect_reply("\n!\r\n", "timeout", 1'b0, lat);
        chk("timeout req_len", last_req_len, 255);
        ack_en = 1'b1;

        // backspace editing
        rdata_val = 16'h0C3D;
        send_byte(8'h72);
        send_byte(8'h78);
        send_byte(8'h08);
        send_line("d 0010");
        collect_reply("\n0C3D\r\n", "backspace", 1'b0, lat);
        chk("backspace addr", {16'h0, seen_addr}, 32'h0010);
        chk("backspace space", {31'h0, seen_space}, 0);

        // reset during SEND
        i_tx_ready = 1'b0;
        send_line("g");
        for (int c = 0; c < 20 && !o_tx_valid; c++) @(negedge clk);
        chk("midrst pre_valid", {31'h0, o_tx_valid}, 1);
        chk("midrst pre_running", {31'h0, o_running}, 1);
        RST = 1'b1;
        @(negedge clk);
        chk("midrst tx_valid", {31'h0, o_tx_valid}, 0);
        chk("midrst busy", {31'h0, o_busy}, 0);
        chk("midrst running", {31'h0, o_running}, 0);
        RST = 1'b0;
        i_tx_ready = 1'b1;
        @(negedge clk);
        rdata_val = 16'h7E00;
        send_line("rm 0002");
        collect_reply("\n7E00\r\n", "post_rst", 1'b0, lat);
        chk("post_rst space", {31'h0, seen_space}, 1);
        chk("post_rst addr", {16'h0, seen_addr}, 32'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
